// File: rtl/if_id_pkg.sv
// Shared constants for the IF/ID elastic stage.
package if_id_pkg;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : if_id_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/if_id_elastic_stage.sv
// IF/ID stage register with valid/ready handshake and a main+skid buffer.
// Define IF_ID_ELASTIC_PERF_EN to add saturating stall/flush counters.
module if_id_elastic_stage
    import if_id_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 SIDE_W    = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(if_id_pkg::NOP_INSTR)
`ifdef IF_ID_ELASTIC_PERF_EN
    ,
    parameter int                 CNT_W     = 16
`endif
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [SIDE_W-1:0]  in_side,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [SIDE_W-1:0]  out_side
`ifdef IF_ID_ELASTIC_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [SIDE_W-1:0]  side;
    } if_id_entry_t;

    if_id_entry_t main_q;
    if_id_entry_t skid_q;
    if_id_entry_t in_entry;
    logic         main_valid;
    logic         skid_valid;
    logic         accept;
    logic         pop;

    assign in_entry = '{pc: in_pc, instr: in_instr, side: in_side};

    // Ready depends only on registered state, so no out_ready -> in_ready path.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign pop      = main_valid & out_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            // NOTE: data registers are reset too; outputs are masked anyway, but every flop has a defined value.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                // NOTE: non-blocking assignments keep every register update tied to the same edge.
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end
        end else if (!skid_valid) begin
            if (accept && pop) begin
                main_q <= in_entry;
            end else if (accept) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end else if (pop) begin
                main_valid <= 1'b0;
            end
        end else if (pop) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
        end
    end

    assign out_valid = main_valid;
    assign out_pc    = main_valid ? main_q.pc    : '0;
    assign out_instr = main_valid ? main_q.instr : NOP_INSTR;
    assign out_side  = main_valid ? main_q.side  : '0;

`ifdef IF_ID_ELASTIC_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstN  (rstN),
        .inc   (main_valid & ~out_ready),
        .count (stall_cnt)
    );

    // Only flushes that actually kill something are counted.
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rstN  (rstN),
        .inc   (flush & (main_valid | skid_valid)),
        .count (flush_cnt)
    );
`else
    // Counters absent: no extra ports, datapath identical.
`endif

endmodule : if_id_elastic_stage

// File: tb/tb_if_id_elastic_stage.sv
// Scoreboard bench: driver pushes accepted entries, monitor pops on each decode consume.
module tb_if_id_elastic_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        side;
    } entry_t;

    logic        clk;
    logic        rstN;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [0:0]  in_side;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [0:0]  out_side;
`ifdef IF_ID_ELASTIC_PERF_EN
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;
`endif

    entry_t exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    logic   acc;

    if_id_elastic_stage #(
        .PC_W    (32),
        .INSTR_W (32),
        .SIDE_W  (1)
`ifdef IF_ID_ELASTIC_PERF_EN
        ,
        .CNT_W   (4)
`endif
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_side   (in_side),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_side  (out_side)
`ifdef IF_ID_ELASTIC_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle from posedge+1; bookkeeping after the monitor has sampled.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic fl,
                         input logic ordy, output logic accepted);
        entry_t e;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        in_side   = pc[2];
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        #1;
        accepted = v && in_ready;
        if (fl) begin
            exp_q.delete();
        end else if (accepted) begin
            e.pc    = pc;
            e.instr = instr_of(pc);
            e.side  = pc[2];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_instr"}, 64'(out_instr), 64'(NOP));
        check({name, "_pc"},    64'(out_pc),    64'd0);
        check({name, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    // Monitor: every consume by decode must match the oldest accepted entry.
    always @(negedge clk) begin
        if (rstN && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc %0h expected no entry", out_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("mon_pc",    64'(out_pc),    64'(e.pc));
                check("mon_instr", 64'(out_instr), 64'(e.instr));
                check("mon_side",  64'(out_side),  64'(e.side));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN      = 1'b0;
        in_valid  = 1'b1;
        in_pc     = $urandom;
        in_instr  = $urandom;
        in_side   = 1'($urandom);
        flush     = 1'($urandom);
        out_ready = 1'($urandom);
        #1;
        check_idle("reset_t1");
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_held");

        rstN     = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;

        // First entry: visible exactly one cycle after accept
        cycle(1'b1, 32'h100, 1'b0, 1'b0, acc);
        check("first_acc",   64'(acc),       64'd1);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_pc",    64'(out_pc),    64'h100);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("first_drained", 64'(out_valid), 64'd0);

        // Streaming at full throughput
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(i * 4), 1'b0, 1'b1, acc);
            check("stream_acc",   64'(acc),       64'd1);
            check("stream_ready", 64'(in_ready),  64'd1);
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure into the skid entry
        cycle(1'b1, 32'h0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h4, 1'b0, 1'b0, acc);
        check("bp_skid_acc",  64'(acc),      64'd1);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, acc);
        check("bp_08_held", 64'(acc), 64'd0);
        cycle(1'b1, 32'h8, 1'b0, 1'b1, acc);
        check("bp_08_still_held", 64'(acc), 64'd0);
        check("bp_ready_back",    64'(in_ready), 64'd1);
        cycle(1'b1, 32'h8, 1'b0, 1'b1, acc);
        check("bp_08_acc", 64'(acc), 64'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Flush with both entries full and fetch offering in the same cycle
        cycle(1'b1, 32'h200, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h204, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h208, 1'b1, 1'b0, acc);
        check_idle("flush_full");
        // Flush with an accept and a pop in the flush cycle
        cycle(1'b1, 32'h400, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h404, 1'b1, 1'b1, acc);
        check_idle("flush_accept");
        cycle(1'b1, 32'h300, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("flush_queue_empty", 64'(exp_q.size()), 64'd0);

        // Async reset between edges while the stage is full
        cycle(1'b1, 32'h500, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h504, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        cycle(1'b1, 32'h600, 1'b0, 1'b1, acc);
        check("resume_pc", 64'(out_pc), 64'h600);
        cycle(1'b1, 32'h604, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("resume_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef IF_ID_ELASTIC_PERF_EN
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("flush_cnt_empty", 64'(flush_cnt), 64'd0);
        check("stall_cnt_zero",  64'(stall_cnt), 64'd0);
        cycle(1'b1, 32'h700, 1'b0, 1'b0, acc);
        repeat (20) cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        check("stall_cnt_sat", 64'(stall_cnt), 64'd15);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("flush_cnt_one", 64'(flush_cnt), 64'd1);
`endif

        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_if_id_elastic_stage
